// File: rtl/sram_arb_pkg.sv
// Shared widths, response latency and the request bundle
// for the sky130 1R1W SRAM arbiter.
package sram_arb_pkg;

  localparam int ADDR_W     = 10;
  localparam int DATA_W     = 32;
  localparam int NUM_WMASKS = 4;
  localparam int RSP_LAT    = 2;

  typedef struct packed {
    logic                  we;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [NUM_WMASKS-1:0] wstrb;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer flips only
// when both requesters compete in the same cycle.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = i_req;
    if (&i_req)
      o_gnt = r_ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= 1'b0;
    else if (&i_req)
      r_ptr <= ~r_ptr;
  end

endmodule

// File: rtl/sram_1r1w_arbiter.sv
// Two-requester arbiter onto a 1R1W SRAM macro.
// Optional stall counters: define SRAM_ARB_PERF_EN.
module sram_1r1w_arbiter
  import sram_arb_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic                  req0_we,
  input  logic [ADDR_W-1:0]     req0_addr,
  input  logic [DATA_W-1:0]     req0_wdata,
  input  logic [NUM_WMASKS-1:0] req0_wstrb,
  output logic                  req0_ready,
  output logic                  rsp0_valid,
  output logic [DATA_W-1:0]     rsp0_rdata,
  input  logic                  req1_valid,
  input  logic                  req1_we,
  input  logic [ADDR_W-1:0]     req1_addr,
  input  logic [DATA_W-1:0]     req1_wdata,
  input  logic [NUM_WMASKS-1:0] req1_wstrb,
  output logic                  req1_ready,
  output logic                  rsp1_valid,
  output logic [DATA_W-1:0]     rsp1_rdata,
  output logic                  sram_csb0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_W-1:0]     sram_addr0,
  output logic [DATA_W-1:0]     sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_W-1:0]     sram_addr1,
  input  logic [DATA_W-1:0]     sram_dout1
`ifdef SRAM_ARB_PERF_EN
  ,
  output logic [15:0]           stall0_cnt,
  output logic [15:0]           stall1_cnt
`endif
);

  req_t                  w_req [2];
  logic [1:0]            w_vld;
  logic [1:0]            w_wcand;
  logic [1:0]            w_rcand;
  logic [1:0]            w_wgnt;
  logic [1:0]            w_rgnt;
  logic [ADDR_W-1:0]     w_waddr;
  logic [DATA_W-1:0]     w_wdata;
  logic [NUM_WMASKS-1:0] w_wstrb;
  logic [ADDR_W-1:0]     w_raddr;

  logic [1:0]            r_pv  [RSP_LAT];
  logic [1:0]            r_prd [RSP_LAT];
  logic [1:0]            r_rsp_v;
  logic [DATA_W-1:0]     r_rdata0;
  logic [DATA_W-1:0]     r_rdata1;

  assign w_req[0] = {req0_we, req0_addr,
                     req0_wdata, req0_wstrb};
  assign w_req[1] = {req1_we, req1_addr,
                     req1_wdata, req1_wstrb};
  assign w_vld    = {req1_valid, req0_valid};

  always_comb begin
    w_wcand = '0;
    for (int n = 0; n < 2; n++)
      w_wcand[n] = w_vld[n] & w_req[n].we;
  end

  rr_arb2 u_warb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_wcand),
    .o_gnt (w_wgnt)
  );

  assign w_waddr = w_wgnt[1] ? w_req[1].addr  : w_req[0].addr;
  assign w_wdata = w_wgnt[1] ? w_req[1].wdata : w_req[0].wdata;
  assign w_wstrb = w_wgnt[1] ? w_req[1].wstrb : w_req[0].wstrb;

  // Same-address read would race the write at the macro's negedge.
  always_comb begin
    w_rcand = '0;
    for (int n = 0; n < 2; n++)
      w_rcand[n] = w_vld[n] & ~w_req[n].we &
                   ~(|w_wgnt && (w_req[n].addr == w_waddr));
  end

  rr_arb2 u_rarb (
    .clk   (clk),
    .rst   (rst),
    .i_req (w_rcand),
    .o_gnt (w_rgnt)
  );

  assign w_raddr    = w_rgnt[1] ? w_req[1].addr : w_req[0].addr;
  assign req0_ready = w_wgnt[0] | w_rgnt[0];
  assign req1_ready = w_wgnt[1] | w_rgnt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sram_csb0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      sram_csb1   <= 1'b1;
      sram_addr1  <= '0;
    end else begin
      sram_csb0 <= 1'b1;
      sram_csb1 <= 1'b1;
      if (|w_wgnt && |w_wstrb) begin
        sram_csb0   <= 1'b0;
        sram_wmask0 <= w_wstrb;
        sram_addr0  <= w_waddr;
        sram_din0   <= w_wdata;
      end
      if (|w_rgnt) begin
        sram_csb1  <= 1'b0;
        sram_addr1 <= w_raddr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RSP_LAT; i++) begin
        r_pv[i]  <= '0;
        r_prd[i] <= '0;
      end
      r_rsp_v  <= '0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_pv[0]  <= w_wgnt | w_rgnt;
      r_prd[0] <= w_rgnt;
      for (int i = 1; i < RSP_LAT; i++) begin
        r_pv[i]  <= r_pv[i-1];
        r_prd[i] <= r_prd[i-1];
      end
      r_rsp_v  <= r_pv[RSP_LAT-1];
      r_rdata0 <= r_prd[RSP_LAT-1][0] ? sram_dout1 : '0;
      r_rdata1 <= r_prd[RSP_LAT-1][1] ? sram_dout1 : '0;
    end
  end

  assign rsp0_valid = r_rsp_v[0];
  assign rsp1_valid = r_rsp_v[1];
  assign rsp0_rdata = r_rdata0;
  assign rsp1_rdata = r_rdata1;

`ifdef SRAM_ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall0_cnt <= '0;
      stall1_cnt <= '0;
    end else begin
      if (req0_valid && !req0_ready && stall0_cnt != 16'hFFFF)
        stall0_cnt <= stall0_cnt + 16'd1;
      if (req1_valid && !req1_ready && stall1_cnt != 16'hFFFF)
        stall1_cnt <= stall1_cnt + 16'd1;
    end
  end
`endif

endmodule
